// File: rtl/feeder_pkg.sv
// Shared types and default sizing for the systolic skew feeder.
package feeder_pkg;

  typedef enum logic {
    LOAD,
    STREAM
  } state_t;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_STREAM_LEN = DEF_DEPTH + DEF_WIDTH - 1;

  function automatic int unsigned stream_len(input int unsigned width, input int unsigned depth);
    return depth + width - 1;
  endfunction

endpackage

// File: rtl/feeder_tile_buf.sv
// DEPTHxWIDTH tile register file: one word write port, per-lane diagonal bit read
// (lane j returns bit j of row step-j, qualified by whether that row exists).
module feeder_tile_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CW-1:0]    rd_step,
  output logic [WIDTH-1:0] rd_bits,
  output logic [WIDTH-1:0] rd_valid
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_bits  = '0;
    rd_valid = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if ((32'(rd_step) >= j) && (32'(rd_step) < j + DEPTH)) begin
        rd_valid[j] = 1'b1;
        rd_bits[j]  = mem[AW'(32'(rd_step) - j)][j];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers a DEPTH-word tile and streams it diagonally skewed into WIDTH array lanes.
// Define SKEW_FEEDER_DBUF_EN for a second (back) tile buffer loaded during STREAM.
module systolic_skew_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] lane_out,
  output logic [WIDTH-1:0] lane_valid,
  output logic             busy,
  output logic             tile_done
);

  localparam int unsigned   CW     = $clog2(DEPTH + WIDTH);
  localparam int unsigned   AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_T = CW'(stream_len(WIDTH, DEPTH) - 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t           state, state_nx;
  logic [CW-1:0]    t, t_nx, wcnt, wcnt_nx, wcnt_inc, rd_step;
  logic [WIDTH-1:0] lane_nx, lvalid_nx, rd_bits, rd_valid;
  logic             hs;

  assign hs        = in_valid & in_ready;
  assign wcnt_inc  = hs ? wcnt + ONE : wcnt;
  assign busy      = (state == STREAM);
  assign tile_done = ena & (state == STREAM) & (t == LAST_T);

`ifdef SKEW_FEEDER_DBUF_EN
  logic             front, front_nx, rd_sel, wr_sel;
  logic [WIDTH-1:0] rd_bits0, rd_bits1, rd_valid0, rd_valid1;

  // LOAD fills the front buffer; STREAM reads front while filling the back one.
  assign in_ready = ena & ((state == LOAD) | (wcnt != FULL));
  assign wr_sel   = (state == LOAD) ? front : ~front;
  assign rd_bits  = rd_sel ? rd_bits1 : rd_bits0;
  assign rd_valid = rd_sel ? rd_valid1 : rd_valid0;

  feeder_tile_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) u_buf0 (
    .clk      (clk),
    .wr_en    (hs & ~wr_sel),
    .wr_addr  (wcnt[AW-1:0]),
    .wr_data  (in_data),
    .rd_step  (rd_step),
    .rd_bits  (rd_bits0),
    .rd_valid (rd_valid0)
  );

  feeder_tile_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) u_buf1 (
    .clk      (clk),
    .wr_en    (hs & wr_sel),
    .wr_addr  (wcnt[AW-1:0]),
    .wr_data  (in_data),
    .rd_step  (rd_step),
    .rd_bits  (rd_bits1),
    .rd_valid (rd_valid1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) front <= 1'b0;
    else        front <= front_nx;
  end
`else
  assign in_ready = ena & (state == LOAD);

  feeder_tile_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) u_buf0 (
    .clk      (clk),
    .wr_en    (hs),
    .wr_addr  (wcnt[AW-1:0]),
    .wr_data  (in_data),
    .rd_step  (rd_step),
    .rd_bits  (rd_bits),
    .rd_valid (rd_valid)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      t          <= '0;
      wcnt       <= '0;
      lane_out   <= '0;
      lane_valid <= '0;
    end else begin
      state      <= state_nx;
      t          <= t_nx;
      wcnt       <= wcnt_nx;
      lane_out   <= lane_nx;
      lane_valid <= lvalid_nx;
    end
  end

  // Lane registers are loaded with the read of the step they will display next.
  always_comb begin
    state_nx  = state;
    t_nx      = t;
    wcnt_nx   = wcnt;
    lane_nx   = lane_out;
    lvalid_nx = lane_valid;
    rd_step   = '0;
`ifdef SKEW_FEEDER_DBUF_EN
    front_nx  = front;
    rd_sel    = front;
`endif
    if (ena) begin
      unique case (state)
        LOAD: begin
          wcnt_nx = wcnt_inc;
          if (wcnt_inc == FULL) begin
            state_nx  = STREAM;
            t_nx      = '0;
            wcnt_nx   = '0;
            lane_nx   = rd_bits;
            lvalid_nx = rd_valid;
          end
        end
        STREAM: begin
          if (t != LAST_T) begin
            t_nx      = t + ONE;
            rd_step   = t + ONE;
            lane_nx   = rd_bits;
            lvalid_nx = rd_valid;
`ifdef SKEW_FEEDER_DBUF_EN
            wcnt_nx   = wcnt_inc;
`endif
          end else begin
            state_nx  = LOAD;
            t_nx      = '0;
            wcnt_nx   = '0;
            lane_nx   = '0;
            lvalid_nx = '0;
`ifdef SKEW_FEEDER_DBUF_EN
            // Back buffer becomes front either way; a full one restarts STREAM gaplessly.
            front_nx = ~front;
            rd_sel   = ~front;
            if (wcnt_inc == FULL) begin
              state_nx  = STREAM;
              lane_nx   = rd_bits;
              lvalid_nx = rd_valid;
            end else begin
              wcnt_nx = wcnt_inc;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder against a diagonal-skew reference model.
module tb_systolic_skew_feeder;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int SL = D + W - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, busy, tile_done;
  logic [W-1:0] lane_out, lane_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] tile   [D];
  logic [W-1:0] tile_b [D];

  systolic_skew_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lane_out   (lane_out),
    .lane_valid (lane_valid),
    .busy       (busy),
    .tile_done  (tile_done)
  );

  always #5 clk = ~clk;

  // Lane j at step t carries bit j of word t-j when that word exists, else 0.
  function automatic logic [W-1:0] model_lane(input logic [W-1:0] tl [D], input int t, input bit want_valid);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) begin
      if (t - j >= 0 && t - j < D) r[j] = want_valid ? 1'b1 : tl[t - j][j];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input bit gapped);
    int n = 0;
    int cyc = 0;
    while (n < D && cyc < 200) begin
      in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? tile[n] : W'($urandom);
      #2;
      if (in_valid && in_ready) n++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n != D) $display("FAIL load_timeout: accepted %0d words, required %0d", n, D);
    else n_pass++;
  endtask

  task automatic test_stream(input string name, input int stall_at, input int abort_at, input bit drive_valid);
    logic [2*W+2:0] exp_v, got_v;
    for (int t = 0; t < SL; t++) begin
      if (t == abort_at) return;
      if (t == stall_at) begin
        ena = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #2;
          exp_v = {model_lane(tile, t, 0), model_lane(tile, t, 1), 1'b1, 1'b0, 1'b0};
          got_v = {lane_out, lane_valid, busy, tile_done, in_ready};
          n_checks++;
          if (got_v !== exp_v) $display("FAIL %s_stall t=%0d: got %h required %h", name, t, got_v, exp_v);
          else n_pass++;
          step();
        end
        ena = 1'b1;
      end
      in_valid = drive_valid;
      in_data  = W'($urandom);
      #2;
`ifdef SKEW_FEEDER_DBUF_EN
      exp_v = {model_lane(tile, t, 0), model_lane(tile, t, 1), 1'b1, (t == SL - 1), 1'b1};
`else
      exp_v = {model_lane(tile, t, 0), model_lane(tile, t, 1), 1'b1, (t == SL - 1), 1'b0};
`endif
      got_v = {lane_out, lane_valid, busy, tile_done, in_ready};
      n_checks++;
      if (got_v !== exp_v) $display("FAIL %s t=%0d: got %h required %h", name, t, got_v, exp_v);
      else n_pass++;
      step();
    end
    in_valid = 1'b0;
    #2;
    exp_v = {{(2*W){1'b0}}, 1'b0, 1'b0, 1'b1};
    got_v = {lane_out, lane_valid, busy, tile_done, in_ready};
    n_checks++;
    if (got_v !== exp_v) $display("FAIL %s_end: got %h required %h", name, got_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step(); step(); step();
    #2;
    n_checks++;
    if ({lane_out, lane_valid, busy, tile_done, in_ready} !== {{(2*W){1'b0}}, 3'b001})
      $display("FAIL reset_hold: got %h required %h", {lane_out, lane_valid, busy, tile_done, in_ready}, {{(2*W){1'b0}}, 3'b001});
    else n_pass++;
    rst_n = 1'b1;
    step();
    #2;
    n_checks++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL reset_release: busy/ready %b required 01", {busy, in_ready});
    else n_pass++;
  endtask

  task automatic test_identity();
    for (int k = 0; k < D; k++) tile[k] = W'(1) << k;
    load_tile(1'b0);
    test_stream("identity", -1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < D; k++) tile[k] = W'($urandom);
      load_tile(1'b1);
      test_stream("random", -1, -1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    for (int k = 0; k < D; k++) tile[k] = '1;
    for (int c = 0; c < 2 * D - 1; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = '1;
      #2;
      if (in_valid && in_ready) cnt++;
      step();
    end
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (cnt != D || busy !== 1'b1) $display("FAIL gapped_load: accepted %0d busy %b required %0d busy 1", cnt, busy, D);
    else n_pass++;
`ifdef SKEW_FEEDER_DBUF_EN
    test_stream("gapped", -1, -1, 1'b0);
`else
    test_stream("valid_in_stream", -1, -1, 1'b1);
`endif
  endtask

  task automatic test_ena_stall();
    for (int k = 0; k < D; k++) tile[k] = W'($urandom);
    load_tile(1'b0);
    test_stream("ena_stall", 5, -1, 1'b0);
  endtask

  task automatic test_midreset();
    for (int k = 0; k < D; k++) tile[k] = W'($urandom);
    load_tile(1'b0);
    test_stream("pre_reset", -1, 6, 1'b0);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({lane_out, lane_valid, busy, tile_done, in_ready} !== {{(2*W){1'b0}}, 3'b001})
      $display("FAIL midreset: got %h required %h", {lane_out, lane_valid, busy, tile_done, in_ready}, {{(2*W){1'b0}}, 3'b001});
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < D; k++) tile[k] = 8'hA5;
    load_tile(1'b0);
    test_stream("after_reset", -1, -1, 1'b0);
  endtask

`ifdef SKEW_FEEDER_DBUF_EN
  task automatic test_back_to_back();
    logic [2*W+2:0] exp_v, got_v;
    int nb = 0;
    for (int k = 0; k < D; k++) begin
      tile[k]   = W'($urandom);
      tile_b[k] = W'($urandom);
    end
    load_tile(1'b0);
    for (int cyc = 0; cyc < 2 * SL; cyc++) begin
      if (cyc == SL) tile = tile_b;
      in_valid = (cyc < SL) && (nb < D);
      in_data  = in_valid ? tile_b[nb] : '0;
      #2;
      exp_v = {model_lane(tile, cyc % SL, 0), model_lane(tile, cyc % SL, 1), 1'b1,
               (cyc % SL == SL - 1), (cyc >= SL) || (nb < D)};
      got_v = {lane_out, lane_valid, busy, tile_done, in_ready};
      n_checks++;
      if (got_v !== exp_v) $display("FAIL back_to_back cyc=%0d: got %h required %h", cyc, got_v, exp_v);
      else n_pass++;
      if (in_valid) nb++;
      step();
    end
    in_valid = 1'b0;
    #2;
    n_checks++;
    if ({busy, lane_valid, in_ready} !== {1'b0, {W{1'b0}}, 1'b1})
      $display("FAIL back_to_back_end: busy %b valid %h ready %b", busy, lane_valid, in_ready);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_random();
    test_backpressure();
    test_ena_stall();
    test_midreset();
`ifdef SKEW_FEEDER_DBUF_EN
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
